// File: rtl/myproject_div_29s_15ns_16_seq.sv
// myproject_div_29s_15ns_16_seq
// Sequential signed-by-unsigned radix-2 restoring divider. It divides a
// din0_WIDTH-bit two's-complement dividend by a din1_WIDTH-bit unsigned
// divisor and produces one quotient bit per clock. The quotient is truncated
// toward zero and saturated to dout_WIDTH signed bits. The remainder takes
// the sign of the dividend and is always exact.
//
// Ports
//   ap_clk, ap_rst_n     : clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready  : operand handshake; operands are accepted only in IDLE
//   din0                 : dividend, two's complement
//   din1                 : divisor, unsigned
//   out_valid / out_ready: result handshake; the result holds until taken
//   quot                 : saturated signed quotient
//   rem                  : signed remainder, |rem| < din1
//   ovf                  : quotient was clamped
//   dz                   : divisor was zero
module myproject_div_29s_15ns_16_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 29,
  parameter int din1_WIDTH = 15,
  parameter int dout_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [dout_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dz
);

  localparam int CW = $clog2(din0_WIDTH);
  localparam int PW = din1_WIDTH + 1;

  localparam logic [CW-1:0] CNT_LOAD = CW'(din0_WIDTH - 1);

  // Saturation limits expressed on the quotient magnitude.
  localparam logic [din0_WIDTH-1:0] MAG_POS = din0_WIDTH'((64'd1 << (dout_WIDTH - 1)) - 64'd1);
  localparam logic [din0_WIDTH-1:0] MAG_NEG = din0_WIDTH'(64'd1 << (dout_WIDTH - 1));

  localparam logic [dout_WIDTH-1:0] QMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] QMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t                  state;
  logic                    sign;
  logic [din0_WIDTH-1:0]   dq;     // dividend bits shift out the top, quotient bits shift in the bottom
  logic [PW-1:0]           prem;   // partial remainder
  logic [din1_WIDTH-1:0]   dvs;
  logic [CW-1:0]           cnt;

  logic [PW-1:0]           shifted;
  logic [PW-1:0]           trial;
  logic                    ge;
  logic [PW-1:0]           prem_nxt;
  logic [din0_WIDTH-1:0]   dq_nxt;
  logic [din0_WIDTH-1:0]   din0_mag;
  logic [dout_WIDTH-1:0]   fin_q;
  logic [dout_WIDTH-1:0]   fin_r;
  logic                    fin_ovf;
  logic [dout_WIDTH-1:0]   rmag_ext;

  // One restoring step. The final step's results feed the finalize logic
  // directly, so the last iteration and the entry to DONE share one edge.
  always_comb begin
    shifted  = {prem[PW-2:0], dq[din0_WIDTH-1]};
    trial    = shifted - {1'b0, dvs};
    ge       = (shifted >= {1'b0, dvs});
    prem_nxt = ge ? trial : shifted;
    dq_nxt   = {dq[din0_WIDTH-2:0], ge};
  end

  always_comb begin
    din0_mag = din0[din0_WIDTH-1] ? ('0 - din0) : din0;
  end

  always_comb begin
    fin_q   = '0;
    fin_ovf = 1'b0;
    if (!sign) begin
      if (dq_nxt > MAG_POS) begin
        fin_q   = QMAX;
        fin_ovf = 1'b1;
      end else begin
        fin_q = dq_nxt[dout_WIDTH-1:0];
      end
    end else begin
      if (dq_nxt > MAG_NEG) begin
        fin_q   = QMIN;
        fin_ovf = 1'b1;
      end else begin
        // A magnitude of exactly 2^(dout_WIDTH-1) negates onto QMIN without overflow.
        fin_q = '0 - dq_nxt[dout_WIDTH-1:0];
      end
    end
    rmag_ext = dout_WIDTH'(prem_nxt[din1_WIDTH-1:0]);
    fin_r    = sign ? ('0 - rmag_ext) : rmag_ext;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
      sign      <= 1'b0;
      dq        <= '0;
      prem      <= '0;
      dvs       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (din1 == '0) begin
              quot      <= din0[din0_WIDTH-1] ? QMIN : QMAX;
              rem       <= '0;
              ovf       <= 1'b0;
              dz        <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              sign  <= din0[din0_WIDTH-1];
              dq    <= din0_mag;
              prem  <= '0;
              dvs   <= din1;
              cnt   <= CNT_LOAD;
              state <= CALC;
            end
          end
        end

        CALC: begin
          prem <= prem_nxt;
          dq   <= dq_nxt;
          if (cnt == '0) begin
            quot      <= fin_q;
            rem       <= fin_r;
            ovf       <= fin_ovf;
            dz        <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/myproject_div_29s_15ns_16_seq.md
# myproject_div_29s_15ns_16_seq

Sequential signed-by-unsigned divider: the inverse of the 16s×15ns→29 product path in the quantized CNN datapath. It takes a 29-bit signed accumulator and a 15-bit unsigned scale, and returns a saturated 16-bit signed quotient and an exact remainder. It sits on requantization/normalization paths where a product must be rescaled back to the 16-bit activation width. The core is a radix-2 restoring divider: one quotient bit per clock, with valid/ready handshakes on both sides.

## Interface
- ID, 1: instance tag, no functional effect
- din0_WIDTH, 29: dividend width (signed); also the iteration count
- din1_WIDTH, 15: divisor width (unsigned)
- dout_WIDTH, 16: quotient and remainder width (signed)

Ports:
- ap_clk  in  1  single clock, all state on rising edge
- ap_rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- din0  in  din0_WIDTH  dividend, two's complement
- din1  in  din1_WIDTH  divisor, unsigned
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- quot  out  dout_WIDTH  quotient, truncated toward zero, saturated
- rem  out  dout_WIDTH  remainder, sign of dividend, |rem| < din1
- ovf  out  1  quotient was saturated
- dz  out  1  divisor was zero

## Operation
- States: IDLE, CALC, DONE.
- In IDLE, in_ready=1. The transfer is accepted when in_valid&&in_ready; operands are registered.
- On accept:
  - If din1==0, go to DONE with dz=1, quot=+32767 (dividend ≥0) or −32768 (dividend <0), rem=0, ovf=0.
  - Otherwise register sign=din0[MSB] and |din0| as an unsigned 29-bit value (|−2^28| = 2^28 fits), clear the partial remainder, load the iteration counter with din0_WIDTH−1, and go to CALC.
- CALC, each cycle:
  - Shift the remainder left and bring in the next dividend MSB.
  - If the remainder ≥ divisor, subtract and set quotient bit=1; otherwise set the bit to 0.
  - Decrement the counter; after the iteration at count 0, go to DONE.
  - The partial remainder needs din1_WIDTH+1 bits; the full magnitude quotient is 29 bits.
- Entry to DONE computes:
  - Signed quotient = sign ? −Qmag : Qmag.
  - Saturate to [−32768, +32767]; ovf=1 if clamped.
  - rem = sign ? −Rmag : Rmag. This is always exact, independent of saturation.
- DONE: out_valid=1, with quot/rem/ovf/dz held stable. Return to IDLE on out_valid&&out_ready.
  - in_ready=0 in DONE, so there is no same-cycle accept. Minimum spacing between accepts is 31 cycles for a nonzero divisor.
- in_valid/din0/din1 are ignored outside IDLE. A late change of operands after accept has no effect.
- Reset mid-operation (any state): return immediately to IDLE. Any in-flight result is discarded and no out_valid is produced for it.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, quot=0, rem=0, ovf=0, dz=0.
- Latency from the accepting edge E to out_valid high:
  - Nonzero divisor: 29 CALC edges plus one finalize. out_valid is first sampled high at edge E+30.
  - din1==0: out_valid is high at edge E+1.
- Result outputs are registered and change only on the transition into DONE. They hold their value through IDLE until the next result.
- out_valid holds indefinitely under out_ready=0. If out_ready=1 on the first DONE cycle, out_valid is high for exactly one cycle.
- in_ready rises on the edge that retires the result.

## Test plan
- din0=100, din1=7, out_ready=1: quot=14, rem=2, ovf=0, dz=0; out_valid exactly 30 edges after accept, one cycle wide.
- din0=−100, din1=7: quot=−14, rem=−2. Also din0=−268435456 (−2^28), din1=1: quot=−32768, ovf=1, rem=0.
- din0=1000000, din1=3: quot=32767, ovf=1, rem=1. Also din0=−65536, din1=2: quot=−32768, ovf=0, rem=0. Also din0=−65538, din1=2: quot=−32768, ovf=1.
- din1=0 with din0=5, then with din0=−5: dz=1, quot=32767 then −32768, rem=0; out_valid 1 edge after accept.
- Backpressure: out_ready low for 10 cycles after out_valid rises. Outputs stay stable and in_ready=0 throughout, and in_valid pulses in this window are not accepted. When out_ready rises, in_ready=1 on the next cycle.
- Reset asserted 12 cycles into CALC, released 3 cycles later: all outputs at reset values, no out_valid. A subsequent 100/7 returns 14/2 with normal latency.
